ula_16_bits_seq: RTL and testbench
==================================

// Module: ula_16_bits_seq
// PURPOSE
//  Multi-cycle sequencer running 16-bit ops on one shared external 8-bit ULA (74181-compatible s/m/c_in).
//  Accepts a 16-bit request via valid/ready, runs low-byte pass then high-byte pass with carry chained
//  through a register, merges flags, returns the 16-bit result via valid/ready. Sits between the
//  register-file/control side and the ULA datapath; the ULA itself is outside this block.
// PARAMETERS
//  ALU_LAT   0   extra wait cycles per pass before sampling ULA outputs (0 = purely combinational ULA)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   block can accept (high only in IDLE)
//  req_a, req_b  in   16  operands
//  req_s         in   4   ULA function select
//  req_m         in   1   mode: 1 logic, 0 arithmetic
//  req_c_in      in   1   carry into low byte, same polarity as the ULA c_in
//  alu_a, alu_b  out  8   byte operands to ULA
//  alu_s         out  4   function select to ULA
//  alu_m         out  1   mode to ULA
//  alu_c_in      out  1   carry to ULA
//  alu_f         in   8   ULA result
//  alu_c_out     in   1   ULA carry out
//  alu_a_eq_b    in   1   ULA equality flag
//  alu_overflow  in   1   ULA signed-overflow flag
//  rsp_valid     out  1   result present
//  rsp_ready     in   1   consumer takes result
//  rsp_f         out  16  {hi byte, lo byte}
//  rsp_c_out     out  1   carry out of high pass
//  rsp_a_eq_b    out  1   lo a_eq_b AND hi a_eq_b
//  rsp_overflow  out  1   overflow of high pass; forced 0 when m=1
// BEHAVIOUR
//  - States: IDLE -> LO -> HI -> DONE -> IDLE. req_ready = (state==IDLE), combinational.
//  - Accept on req_valid & req_ready: latch a/b/s/m/c_in; later req_* changes are ignored.
//  - LO: alu_a/b = a[7:0]/b[7:0], alu_c_in = latched c_in. Wait counter runs 0..ALU_LAT.
//    At count==ALU_LAT: capture f_lo, carry, eq_lo; go HI.
//  - HI: alu_a/b = a[15:8]/b[15:8], alu_c_in = captured carry, passed through unmodified.
//    Same wait rule. At count==ALU_LAT: capture f_hi, c_out, overflow, eq; go DONE.
//  - DONE: rsp_valid=1. All rsp_* are registered and held stable until rsp_valid & rsp_ready.
//    That edge returns to IDLE. No accept in the same cycle, since req_ready=0 in DONE.
//  - Latency (ALU_LAT=0): rsp_valid rises 2 edges after accept. Throughput: 1 op per (2*(ALU_LAT+1)+2) cycles with rsp_ready=1.
//  - alu_s/alu_m carry the latched value in LO/HI.
//  - alu_* = 0 in IDLE and DONE.
//  - Reset (async, any state): state=IDLE, wait counter=0, rsp_valid=0, rsp_f=0, rsp_c_out=0, rsp_a_eq_b=0,
//    rsp_overflow=0, alu_*=0, req_ready=1 while rst_n low and after release.
//    An in-flight op is dropped; no response is produced.
//  - Flags are combined only as stated; no interpretation of s beyond forwarding.
// TESTING (golden = two chained 8-bit ULAs, lo c_out -> hi c_in, flags merged as above)
//  1 m=0 s=1001 c_in=0 a=00FF b=0001 -> rsp_f=0100, c_out=0, ovf=0, rsp_valid 2 edges after accept.
//  2 m=0 s=1001 c_in=0 a=7FFF b=0001 -> rsp_f=8000, ovf=1; a=8000 b=8000 -> f=0000, ovf=1.
//  3 all 32 {m,s} x c_in{0,1} x a/b in {0000,FFFF,AAAA/5555,00FF/FF00} -> all rsp_* equal golden.
//    m=1 always gives ovf=0.
//  4 rsp_ready=0 for 5 cycles in DONE -> rsp_* constant, req_ready=0.
//    A req_valid pulse in that window is not accepted.
//  5 change req_a/req_b the cycle after accept -> result matches the originally latched operands.
//  6 rst_n low mid-HI -> rsp_valid=0 and req_ready=1 immediately, with no response.
//    Next request completes normally. Repeat 1 with ALU_LAT=2 -> rsp_valid 6 edges after accept.

Source files
------------

// File: rtl/ula_16_bits_seq.sv
// Runs a 16-bit operation as two byte passes (low, then high) through one shared external 8-bit ULA,
// chaining the low-pass carry into the high pass and merging the per-byte flags into a 16-bit result.
module ula_16_bits_seq #(
    parameter int ALU_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_s,
    input  logic        req_m,
    input  logic        req_c_in,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_c_in,
    input  logic [7:0]  alu_f,
    input  logic        alu_c_out,
    input  logic        alu_a_eq_b,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_f,
    output logic        rsp_c_out,
    output logic        rsp_a_eq_b,
    output logic        rsp_overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;

    logic [15:0] a_p0;
    logic [15:0] b_p0;
    logic [3:0]  s_p0;
    logic        m_p0;
    logic        c_in_p0;

    logic [7:0]  f_lo_p1;
    logic        carry_p1;
    logic        eq_lo_p1;

    // Overflow has no meaning for logic operations, so it is suppressed there.
    function automatic logic gate_overflow(input logic ovf, input logic m);
        return ovf & ~m;
    endfunction

    function automatic logic merge_eq(input logic eq_lo, input logic eq_hi);
        return eq_lo & eq_hi;
    endfunction

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign last      = (cnt == CNT_W'(ALU_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_f        <= '0;
            rsp_c_out    <= 1'b0;
            rsp_a_eq_b   <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (accept) state <= S_LO;
                end
                S_LO: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= S_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HI: begin
                    if (last) begin
                        cnt          <= '0;
                        state        <= S_DONE;
                        rsp_valid    <= 1'b1;
                        rsp_f        <= {alu_f, f_lo_p1};
                        rsp_c_out    <= alu_c_out;
                        rsp_a_eq_b   <= merge_eq(eq_lo_p1, alu_a_eq_b);
                        rsp_overflow <= gate_overflow(alu_overflow, m_p0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // p0: request latched on accept; p1: low-pass result held for the high pass and merge.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0    <= req_a;
            b_p0    <= req_b;
            s_p0    <= req_s;
            m_p0    <= req_m;
            c_in_p0 <= req_c_in;
        end
        if (state == S_LO && last) begin
            f_lo_p1  <= alu_f;
            carry_p1 <= alu_c_out;
            eq_lo_p1 <= alu_a_eq_b;
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_s    = '0;
        alu_m    = 1'b0;
        alu_c_in = 1'b0;
        case (state)
            S_LO: begin
                alu_a    = a_p0[7:0];
                alu_b    = b_p0[7:0];
                alu_s    = s_p0;
                alu_m    = m_p0;
                alu_c_in = c_in_p0;
            end
            S_HI: begin
                alu_a    = a_p0[15:8];
                alu_b    = b_p0[15:8];
                alu_s    = s_p0;
                alu_m    = m_p0;
                alu_c_in = carry_p1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ula_16_bits_seq.sv
// Bench for ula_16_bits_seq: a behavioural 8-bit ULA feeds each DUT; results are compared
// against two chained ULA evaluations with the flags merged as the 16-bit operation defines.
module tb_ula_16_bits_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_m, req_c_in;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_s;
    logic [7:0]  alu_a, alu_b, alu_f;
    logic [3:0]  alu_s;
    logic        alu_m, alu_c_in, alu_c_out, alu_a_eq_b, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_c_out, rsp_a_eq_b, rsp_overflow;
    logic [15:0] rsp_f;

    logic        req_valid2, req_ready2, req_m2, req_c_in2;
    logic [15:0] req_a2, req_b2;
    logic [3:0]  req_s2;
    logic [7:0]  alu_a2, alu_b2, alu_f2;
    logic [3:0]  alu_s2;
    logic        alu_m2, alu_c_in2, alu_c_out2, alu_a_eq_b2, alu_overflow2;
    logic        rsp_valid2, rsp_ready2, rsp_c_out2, rsp_a_eq_b2, rsp_overflow2;
    logic [15:0] rsp_f2;

    int errs = 0;
    int checks = 0;

    // 74181-style byte ULA (active-high carry): returns {overflow, a_eq_b, c_out, f}.
    function automatic logic [10:0] ula8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
        logic [7:0] x, y, f;
        logic [8:0] sum;
        logic ovf;
        case (s)
            4'h0: begin x = a;        y = 8'h00;    end
            4'h1: begin x = a | b;    y = 8'h00;    end
            4'h2: begin x = a | ~b;   y = 8'h00;    end
            4'h3: begin x = 8'hFF;    y = 8'h00;    end
            4'h4: begin x = a;        y = a & ~b;   end
            4'h5: begin x = a | b;    y = a & ~b;   end
            4'h6: begin x = a;        y = ~b;       end
            4'h7: begin x = a & ~b;   y = 8'hFF;    end
            4'h8: begin x = a;        y = a & b;    end
            4'h9: begin x = a;        y = b;        end
            4'hA: begin x = a | ~b;   y = a & b;    end
            4'hB: begin x = a & b;    y = 8'hFF;    end
            4'hC: begin x = a;        y = a;        end
            4'hD: begin x = a | b;    y = a;        end
            4'hE: begin x = a | ~b;   y = a;        end
            default: begin x = a;     y = 8'hFF;    end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {8'h00, cin};
        ovf = (x[7] == y[7]) && (sum[7] != x[7]);
        if (m) begin
            case (s)
                4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;   4'h3: f = 8'h00;
                4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;    4'h7: f = a & ~b;
                4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;        4'hB: f = a & b;
                4'hC: f = 8'hFF;     4'hD: f = a | ~b;    4'hE: f = a | b;    default: f = a;
            endcase
        end else begin
            f = sum[7:0];
        end
        return {ovf, (a == b), sum[8], f};
    endfunction

    // Golden 16-bit result {f, c_out, a_eq_b, overflow} from two chained byte ULAs.
    function automatic logic [18:0] golden16(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] s, input logic m, input logic cin);
        logic [10:0] lo, hi;
        lo = ula8(a[7:0], b[7:0], s, m, cin);
        hi = ula8(a[15:8], b[15:8], s, m, lo[8]);
        return {hi[7:0], lo[7:0], hi[8], lo[9] & hi[9], hi[10] & ~m};
    endfunction

    assign {alu_overflow, alu_a_eq_b, alu_c_out, alu_f} = ula8(alu_a, alu_b, alu_s, alu_m, alu_c_in);

    // Second ULA has two register stages of latency, matching ALU_LAT=2.
    logic [21:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= {alu_a2, alu_b2, alu_s2, alu_m2, alu_c_in2};
        pipe2 <= pipe1;
    end
    assign {alu_overflow2, alu_a_eq_b2, alu_c_out2, alu_f2} =
        ula8(pipe2[21:14], pipe2[13:6], pipe2[5:2], pipe2[1], pipe2[0]);

    ula_16_bits_seq #(.ALU_LAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_c_out(rsp_c_out),
        .rsp_a_eq_b(rsp_a_eq_b), .rsp_overflow(rsp_overflow)
    );

    ula_16_bits_seq #(.ALU_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_a(req_a2), .req_b(req_b2),
        .req_s(req_s2), .req_m(req_m2), .req_c_in(req_c_in2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_m(alu_m2), .alu_c_in(alu_c_in2),
        .alu_f(alu_f2), .alu_c_out(alu_c_out2), .alu_a_eq_b(alu_a_eq_b2), .alu_overflow(alu_overflow2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_f(rsp_f2), .rsp_c_out(rsp_c_out2),
        .rsp_a_eq_b(rsp_a_eq_b2), .rsp_overflow(rsp_overflow2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One operation on the ALU_LAT=0 instance; operands are scrambled right after accept,
    // and the response is held for 'hold' cycles with a stray req_valid pulse inside that window.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input int hold,
                          output logic [18:0] got, output int lat);
        int n;
        @(negedge clk);
        req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom); req_s = 4'($urandom);
        req_m = ~m; req_c_in = ~cin;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); n++; #1;
        end
        lat = n;
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        got = {rsp_f, rsp_c_out, rsp_a_eq_b, rsp_overflow};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp", 32'({rsp_valid, rsp_f, rsp_c_out, rsp_a_eq_b, rsp_overflow}), 32'({1'b1, got}));
            check("hold_ready", 32'(req_ready), 32'd0);
            check("done_alu_zero", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in}), 32'd0);
            req_valid = (i == 1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("after_handshake", 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    task automatic run_op2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                           input logic m, input logic cin, output logic [18:0] got, output int lat);
        int n;
        @(negedge clk);
        req_a2 = a; req_b2 = b; req_s2 = s; req_m2 = m; req_c_in2 = cin; req_valid2 = 1'b1;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        req_a2 = 16'($urandom); req_b2 = 16'($urandom);
        n = 0;
        while (!rsp_valid2 && n < 40) begin
            @(posedge clk); n++; #1;
        end
        lat = n;
        got = {rsp_f2, rsp_c_out2, rsp_a_eq_b2, rsp_overflow2};
        @(negedge clk);
        rsp_ready2 = 1'b1;
        @(posedge clk); #1;
        rsp_ready2 = 1'b0;
        check("lat2_after_handshake", 32'({rsp_valid2, req_ready2}), 32'b01);
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic [3:0]  s;
        logic        m, cin;
        logic [15:0] f;
        logic        cout, eq, ovf;
    } vec_t;

    vec_t vecs[5];
    logic [15:0] pats[6];
    logic [18:0] got, exp;
    int lat;

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{16'hAAAA, 16'h5555, 4'b0110, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b0, 16'hF000, 1'b1, 1'b0, 1'b0};
        pats = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h00FF, 16'hFF00};

        rst_n = 1'b0;
        req_valid = 0; req_a = 0; req_b = 0; req_s = 0; req_m = 0; req_c_in = 0; rsp_ready = 0;
        req_valid2 = 0; req_a2 = 0; req_b2 = 0; req_s2 = 0; req_m2 = 0; req_c_in2 = 0; rsp_ready2 = 0;
        #12;
        check("reset_rsp", 32'({rsp_valid, rsp_f, rsp_c_out, rsp_a_eq_b, rsp_overflow}), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, 0, got, lat);
            check($sformatf("vec%0d", i), 32'(got),
                  32'({vecs[i].f, vecs[i].cout, vecs[i].eq, vecs[i].ovf}));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        for (int ms = 0; ms < 32; ms++)
            for (int c = 0; c < 2; c++)
                for (int ia = 0; ia < 6; ia++)
                    for (int ib = 0; ib < 6; ib++) begin
                        run_op(pats[ia], pats[ib], 4'(ms), ms[4], c[0], 0, got, lat);
                        exp = golden16(pats[ia], pats[ib], 4'(ms), ms[4], c[0]);
                        check($sformatf("sweep_m%0d_s%0h_c%0d_%h_%h", ms[4], ms[3:0], c, pats[ia], pats[ib]),
                              32'(got), 32'(exp));
                    end

        for (int i = 0; i < 200; i++) begin
            logic [15:0] ra, rb;
            logic [3:0]  rs;
            logic        rm, rc;
            ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
            rm = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, rm, rc, (i % 25 == 0) ? 5 : 0, got, lat);
            check("random", 32'(got), 32'(golden16(ra, rb, rs, rm, rc)));
        end

        run_op(16'h1234, 16'h0FED, 4'b1001, 1'b0, 1'b1, 5, got, lat);
        check("hold_result", 32'(got), 32'(golden16(16'h1234, 16'h0FED, 4'b1001, 1'b0, 1'b1)));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stray_rsp", 32'(rsp_valid), 32'd0);
        end

        @(negedge clk);
        req_a = 16'h00FF; req_b = 16'h0001; req_s = 4'b1001; req_m = 0; req_c_in = 0; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midhi_reset_ctrl", 32'({rsp_valid, req_ready}), 32'b01);
        check("midhi_reset_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("dropped_op", 32'({rsp_valid, req_ready}), 32'b01);
        end
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, got, lat);
        check("post_reset_op", 32'(got), 32'({16'h0000, 1'b1, 1'b0, 1'b0}));

        run_op2(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, got, lat);
        check("lat2_result", 32'(got), 32'({16'h0100, 1'b0, 1'b0, 1'b0}));
        check("lat2_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            logic [15:0] ra, rb;
            logic [3:0]  rs;
            ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
            run_op2(ra, rb, rs, 1'b0, 1'b1, got, lat);
            check("lat2_random", 32'(got), 32'(golden16(ra, rb, rs, 1'b0, 1'b1)));
            check("lat2_random_latency", 32'(lat), 32'd6);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
